whack_game_core: RTL and testbench

Parametrised successor to the fixed 8-hole game core. It merges mole placement, guess evaluation, scoring and lives into one FSM. The block adds features the first generation lacks: a configurable hole count, a per-mole timeout, a lives counter with game-over, and restart without reset. It sits between the debounced user-input block and the LED/seven-segment display blocks.

---
 rtl/whack_game_core.sv | 174 +++++++++++++++++
 tb/tb_whack_game_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/whack_game_core.sv
// rtl/whack_game_core.sv - whack-a-mole game FSM: mole placement, guess scoring, lives, timeout
// Optional WHACK_SPEEDUP_EN shrinks the mole window on every hit.
module whack_game_core #(
    parameter int          N_HOLES        = 8,
    parameter int          POS_W          = 3,
    parameter int          TIMEOUT_CYCLES = 100000000,
    parameter int          MAX_LIVES      = 3,
    parameter int          SCORE_W        = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
`ifdef WHACK_SPEEDUP_EN
    ,
    parameter int          TIMEOUT_STEP   = TIMEOUT_CYCLES / 16,
    parameter int          TIMEOUT_MIN    = TIMEOUT_CYCLES / 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               guess_valid,
    input  logic [POS_W-1:0]   guess_pos,
    output logic [POS_W-1:0]   mole_pos,
    output logic               mole_valid,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives,
    output logic               hit,
    output logic               miss,
    output logic               timeout,
    output logic               game_over
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [POS_W:0]     HOLES      = (POS_W + 1)'(N_HOLES);
    localparam logic [3:0]         LIVES_INIT = 4'(MAX_LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SPAWN, S_WAIT, S_GAMEOVER} state_t;

    state_t               state, state_next;
    logic [15:0]          lfsr;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_load;
    logic [POS_W:0]       cand_raw;
    logic [POS_W:0]       cand_next;
    logic                 guess_hit;
    logic                 last_life;
    logic                 game_start;

    assign guess_hit  = guess_valid && (guess_pos == mole_pos);
    assign last_life  = (lives == 4'd1);
    assign game_start = start && (state == S_IDLE || state == S_GAMEOVER);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Fold the LFSR into range, then bump by one if it would repeat the last hole.
    always_comb begin
        cand_raw = {1'b0, lfsr[POS_W-1:0]};
        if (cand_raw >= HOLES) begin
            cand_raw = cand_raw - HOLES;
        end
        cand_next = cand_raw;
        if (cand_raw[POS_W-1:0] == mole_pos) begin
            cand_next = cand_raw + (POS_W + 1)'(1);
            if (cand_next >= HOLES) begin
                cand_next = '0;
            end
        end
    end

`ifdef WHACK_SPEEDUP_EN
    localparam logic [TIMER_W-1:0] WIN_INIT = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] WIN_STEP = TIMER_W'(TIMEOUT_STEP);
    localparam logic [TIMER_W-1:0] WIN_MIN  = TIMER_W'(TIMEOUT_MIN);

    logic [TIMER_W-1:0] window;

    always_ff @(posedge clk) begin
        if (!rst || game_start) begin
            window <= WIN_INIT;
        end else if (state == S_WAIT && guess_hit) begin
            window <= (window >= WIN_MIN + WIN_STEP) ? window - WIN_STEP : WIN_MIN;
        end
    end

    assign timer_load = window - TIMER_W'(1);
`else
    assign timer_load = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (start) state_next = S_SPAWN;
            S_SPAWN:    state_next = S_WAIT;
            S_WAIT: begin
                if (guess_hit) begin
                    state_next = S_SPAWN;
                end else if (guess_valid) begin
                    state_next = last_life ? S_GAMEOVER : S_WAIT;
                end else if (timer == '0) begin
                    state_next = last_life ? S_GAMEOVER : S_SPAWN;
                end
            end
            S_GAMEOVER: if (start) state_next = S_SPAWN;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mole_valid = (state == S_WAIT);
        game_over  = (state == S_GAMEOVER);
    end

    // A wrong guess leaves the timer untouched so the mole keeps its remaining window.
    always_ff @(posedge clk) begin
        if (!rst) begin
            score    <= '0;
            lives    <= LIVES_INIT;
            mole_pos <= '0;
            timer    <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            hit     <= 1'b0;
            miss    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE, S_GAMEOVER: begin
                    if (start) begin
                        score <= '0;
                        lives <= LIVES_INIT;
                    end
                end
                S_SPAWN: begin
                    mole_pos <= cand_next[POS_W-1:0];
                    timer    <= timer_load;
                end
                S_WAIT: begin
                    if (guess_hit) begin
                        hit <= 1'b1;
                        if (score != SCORE_MAX) begin
                            score <= score + SCORE_W'(1);
                        end
                    end else if (guess_valid) begin
                        miss  <= 1'b1;
                        lives <= lives - 4'd1;
                    end else if (timer == '0) begin
                        miss    <= 1'b1;
                        timeout <= 1'b1;
                        lives   <= lives - 4'd1;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_whack_game_core.sv
// tb/tb_whack_game_core.sv - scoreboard bench for whack_game_core
module tb_whack_game_core;

    localparam int N  = 6;
    localparam int PW = 3;
    localparam int TC = 20;
    localparam int ML = 3;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          guess_valid = 1'b0;
    logic [PW-1:0] guess_pos = '0;
    logic [PW-1:0] mole_pos;
    logic          mole_valid;
    logic [SW-1:0] score;
    logic [3:0]    lives;
    logic          hit, miss, timeout, game_over;

    whack_game_core #(
        .N_HOLES(N), .POS_W(PW), .TIMEOUT_CYCLES(TC), .MAX_LIVES(ML), .SCORE_W(SW), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .guess_valid(guess_valid), .guess_pos(guess_pos),
        .mole_pos(mole_pos), .mole_valid(mole_valid), .score(score), .lives(lives),
        .hit(hit), .miss(miss), .timeout(timeout), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          exp_score = 0;
    int          exp_lives = ML;
    logic [16:0] exp_q[$];
    logic [16:0] mon_act;

    function automatic logic [16:0] ev(input logic h, input logic m, input logic t,
                                       input logic mv, input logic go, input int sc, input int lv);
        return {h, m, t, mv, go, 8'(sc), 4'(lv)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Every pulse the DUT raises must match the next expected event.
    always @(negedge clk) begin
        if (rst && (hit || miss || timeout)) begin
            mon_act = {hit, miss, timeout, mole_valid, game_over, score, lives};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse actual=%0h required=none", mon_act);
            end else begin
                chk("event {hit,miss,tmo,mv,go,score,lives}", 32'(mon_act), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        guess_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_score = 0;
        exp_lives = ML;
    endtask

    task automatic check_reset();
        chk("rst_score", 32'(score), 0);
        chk("rst_lives", 32'(lives), ML);
        chk("rst_mole_pos", 32'(mole_pos), 0);
        chk("rst_mole_valid", 32'(mole_valid), 0);
        chk("rst_hit", 32'(hit), 0);
        chk("rst_miss", 32'(miss), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_game_over", 32'(game_over), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_score = 0;
        exp_lives = ML;
    endtask

    task automatic wait_mole(output int n);
        n = 0;
        while (!mole_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("mole_wait", 32'(mole_valid), 1);
    endtask

    task automatic do_hit();
        int old;
        int n;
        old = int'(mole_pos);
        guess_pos = mole_pos;
        guess_valid = 1'b1;
        exp_score = (exp_score < 255) ? exp_score + 1 : 255;
        exp_q.push_back(ev(1, 0, 0, 0, 0, exp_score, exp_lives));
        @(negedge clk);
        guess_valid = 1'b0;
        wait_mole(n);
        chk("hit_to_mole_cycles", 32'(n), 1);
        chk("mole_in_range", 32'(int'(mole_pos) < N), 1);
        chk("mole_not_repeated", 32'(int'(mole_pos) != old), 1);
    endtask

    task automatic wrong_guess(input logic [PW-1:0] pos);
        int old;
        old = int'(mole_pos);
        guess_pos = pos;
        guess_valid = 1'b1;
        exp_lives--;
        exp_q.push_back(ev(0, 1, 0, 1, 0, exp_score, exp_lives));
        @(negedge clk);
        guess_valid = 1'b0;
        @(negedge clk);
        chk("mole_held_after_miss", 32'(mole_pos), 32'(old));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int p;

        // Reset values, start, then a hit on the 5th WAIT cycle.
        do_reset();
        check_reset();
        rst = 1'b1;
        do_start();
        wait_mole(n);
        chk("start_to_mole_cycles", 32'(n), 1);
        repeat (4) @(negedge clk);
        do_hit();
        chk("score_after_first_hit", 32'(score), 1);

        // Long run of hits: placement rules and score saturation.
        do_reset();
        rst = 1'b1;
        do_start();
        wait_mole(n);
        for (int i = 0; i < 300; i++) begin
            do_hit();
            if (i == 199) chk("score_200", 32'(score), 200);
        end
        chk("score_saturated", 32'(score), 255);

        // Let three windows expire.
        do_reset();
        rst = 1'b1;
        do_start();
        for (int lv = ML - 1; lv >= 0; lv--) begin
            wait_mole(n);
            exp_lives = lv;
            exp_q.push_back(ev(0, 1, 1, 0, lv == 0, 0, lv));
            repeat (TC) @(negedge clk);
            chk("timeout_on_wait_cycle_20", 32'(timeout), 1);
        end
        @(negedge clk);
        chk("gameover_flag", 32'(game_over), 1);
        chk("gameover_mole_valid", 32'(mole_valid), 0);
        chk("gameover_lives", 32'(lives), 0);

        // Guesses are ignored in GAMEOVER; start restarts the game.
        guess_pos = mole_pos;
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
        @(negedge clk);
        chk("gameover_held", 32'(game_over), 1);
        chk("gameover_lives_held", 32'(lives), 0);
        do_start();
        chk("restart_score", 32'(score), 0);
        chk("restart_lives", 32'(lives), ML);
        chk("restart_game_over", 32'(game_over), 0);
        chk("restart_mole_valid_spawn", 32'(mole_valid), 0);
        @(negedge clk);
        chk("restart_mole_valid_wait", 32'(mole_valid), 1);

        // Wrong, wrong, correct.
        wrong_guess(3'd7);
        p = (int'(mole_pos) + 1) % N;
        wrong_guess(PW'(p));
        chk("lives_after_two_misses", 32'(lives), 1);
        do_hit();

        // A hit on the expiry cycle wins over the timeout.
        repeat (TC - 1) @(negedge clk);
        do_hit();
        chk("lives_after_late_hit", 32'(lives), 1);

        // Reset in the middle of WAIT.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
